eth_rx_monitor: RTL and testbench

- Simulation-side frame checker on the receive interface driven by the Ethernet traffic generator; taps rxd/rx_dv/rx_er in parallel with the MAC RX.
- Delineates frames (preamble/SFD), reassembles MII nibbles into bytes, captures the DST/SRC/length-type header, checks FCS and reports a per-frame summary plus running counters to the testbench scoreboard.

---
 rtl/eth_rx_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_eth_rx_monitor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_monitor.sv
// Receive-side frame checker: delineates preamble/SFD, rebuilds bytes from
// GMII or MII, captures the DST/SRC/length-type header, checks the FCS and
// publishes a per-frame summary with running good/CRC-error counters.
module eth_rx_monitor #(
    parameter int MIN_HDR = 14
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic        mii_mode,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic        frm_done,
    output logic [15:0] frm_len,
    output logic [4:0]  prmbl_len,
    output logic [47:0] dst_addr,
    output logic [47:0] src_addr,
    output logic [15:0] len_type,
    output logic        crc_ok,
    output logic        phy_err,
    output logic        prmbl_err,
    output logic        dribble,
    output logic        short_frm,
    output logic [15:0] frm_cnt,
    output logic [15:0] crc_err_cnt
);

    localparam logic [2:0] S_WAIT_IDLE = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_PRE       = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_DROP      = 3'd4;
    localparam logic [2:0] S_END       = 3'd5;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [15:0] SHORT_LIM   = 16'(MIN_HDR + 4);

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    logic [2:0]  state;
    logic        mii_r;
    logic [4:0]  pcnt;
    logic [15:0] len_r;
    logic [31:0] crc_r;
    logic [47:0] dst_w, src_w;
    logic [15:0] lt_w;
    logic [3:0]  nib_hold;
    logic        nib_vld;
    logic        phy_r, drib_r, perr_r;

    logic        mii_eff;
    logic [4:0]  pcnt_base, pcnt_inc;
    logic        unit_pre, unit_sfd, pre_step;
    logic        byte_vld;
    logic [7:0]  byte_val;
    logic        short_w, crc_ok_w, good_w;

    // Preamble decode, byte assembly and end-of-frame verdicts.
    always_comb begin
        // A new frame may start in IDLE or END, so the mode pin is used live there.
        mii_eff   = mii_r;
        if (state == S_IDLE || state == S_END)
            mii_eff = mii_mode;
        pcnt_base = (state == S_PRE) ? pcnt : 5'd0;
        pcnt_inc  = (pcnt_base == 5'd31) ? pcnt_base : pcnt_base + 5'd1;
        unit_pre  = mii_eff ? (rxd[3:0] == 4'h5) : (rxd == 8'h55);
        unit_sfd  = mii_eff ? (rxd[3:0] == 4'hD && pcnt_base != 5'd0) : (rxd == 8'hD5);
        pre_step  = rx_dv && (state == S_IDLE || state == S_END || state == S_PRE);
        byte_vld  = (state == S_DATA) && rx_dv && (!mii_r || nib_vld);
        byte_val  = mii_r ? {rxd[3:0], nib_hold} : rxd;
        short_w   = len_r < SHORT_LIM;
        crc_ok_w  = !perr_r && (len_r >= 16'd4) && (crc_r == CRC_RESIDUE);
        good_w    = crc_ok_w && !phy_r && !drib_r && !short_w;
    end

    // Frame FSM and per-frame accumulation (length, CRC, header, flags).
    always_ff @(posedge rx_clk) begin
        if (reset) begin
            state    <= S_WAIT_IDLE;
            mii_r    <= 1'b0;
            pcnt     <= '0;
            len_r    <= '0;
            crc_r    <= CRC_INIT;
            dst_w    <= '0;
            src_w    <= '0;
            lt_w     <= '0;
            nib_hold <= '0;
            nib_vld  <= 1'b0;
            phy_r    <= 1'b0;
            drib_r   <= 1'b0;
            perr_r   <= 1'b0;
        end else begin
            case (state)
                S_WAIT_IDLE: if (!rx_dv) state <= S_IDLE;
                S_IDLE, S_END: begin
                    mii_r <= mii_mode;
                    if (rx_dv) begin
                        // Clearing here also covers the SFD clear: nothing
                        // touches these between frame start and SFD.
                        len_r   <= '0;
                        crc_r   <= CRC_INIT;
                        dst_w   <= '0;
                        src_w   <= '0;
                        lt_w    <= '0;
                        nib_vld <= 1'b0;
                        phy_r   <= 1'b0;
                        drib_r  <= 1'b0;
                        perr_r  <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_PRE: if (!rx_dv) begin
                    perr_r <= 1'b1;
                    state  <= S_END;
                end
                S_DATA: begin
                    if (!rx_dv) begin
                        // A pending half byte is dropped, only flagged.
                        drib_r  <= mii_r & nib_vld;
                        nib_vld <= 1'b0;
                        state   <= S_END;
                    end else begin
                        if (rx_er) phy_r <= 1'b1;
                        if (mii_r) begin
                            nib_vld <= ~nib_vld;
                            if (!nib_vld) nib_hold <= rxd[3:0];
                        end
                    end
                    if (byte_vld) begin
                        len_r <= (len_r == 16'hFFFF) ? len_r : len_r + 16'd1;
                        crc_r <= crc32_byte(crc_r, byte_val);
                        for (int i = 0; i < 6; i++) begin
                            if (len_r == 16'(i))     dst_w[8*(5-i) +: 8] <= byte_val;
                            if (len_r == 16'(i + 6)) src_w[8*(5-i) +: 8] <= byte_val;
                        end
                        if (len_r == 16'd12) lt_w[15:8] <= byte_val;
                        if (len_r == 16'd13) lt_w[7:0]  <= byte_val;
                    end
                end
                S_DROP: if (!rx_dv) state <= S_END;
                default: state <= S_WAIT_IDLE;
            endcase
            // Preamble/SFD handling shared by IDLE, END (back-to-back) and PREAMBLE.
            if (pre_step) begin
                if (rx_er) phy_r <= 1'b1;
                if (unit_pre) begin
                    pcnt  <= pcnt_inc;
                    state <= S_PRE;
                end else if (unit_sfd) begin
                    pcnt  <= pcnt_base;
                    state <= S_DATA;
                end else begin
                    pcnt   <= pcnt_base;
                    perr_r <= 1'b1;
                    state  <= S_DROP;
                end
            end
        end
    end

    // Summary publish on leaving END; held until the next frame completes.
    always_ff @(posedge rx_clk) begin
        if (reset) begin
            frm_done    <= 1'b0;
            frm_len     <= '0;
            prmbl_len   <= '0;
            dst_addr    <= '0;
            src_addr    <= '0;
            len_type    <= '0;
            crc_ok      <= 1'b0;
            phy_err     <= 1'b0;
            prmbl_err   <= 1'b0;
            dribble     <= 1'b0;
            short_frm   <= 1'b0;
            frm_cnt     <= '0;
            crc_err_cnt <= '0;
        end else begin
            frm_done <= (state == S_END);
            if (state == S_END) begin
                frm_len   <= len_r;
                prmbl_len <= pcnt;
                dst_addr  <= dst_w;
                src_addr  <= src_w;
                len_type  <= lt_w;
                crc_ok    <= crc_ok_w;
                phy_err   <= phy_r;
                prmbl_err <= perr_r;
                dribble   <= drib_r;
                short_frm <= short_w;
                if (good_w)               frm_cnt     <= frm_cnt + 16'd1;
                if (!perr_r && !crc_ok_w) crc_err_cnt <= crc_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_monitor.sv
// Directed bench for eth_rx_monitor: GMII/MII frames, bad FCS, PHY error,
// bad preamble with back-to-back recovery, dribble nibble, mid-frame reset.
module tb_eth_rx_monitor;

    logic        rx_clk = 1'b0;
    logic        reset, mii_mode, rx_dv, rx_er;
    logic [7:0]  rxd;
    logic        frm_done, crc_ok, phy_err, prmbl_err, dribble, short_frm;
    logic [15:0] frm_len, len_type, frm_cnt, crc_err_cnt;
    logic [4:0]  prmbl_len;
    logic [47:0] dst_addr, src_addr;

    eth_rx_monitor #(.MIN_HDR(14)) dut (
        .rx_clk(rx_clk), .reset(reset), .mii_mode(mii_mode), .rxd(rxd),
        .rx_dv(rx_dv), .rx_er(rx_er), .frm_done(frm_done), .frm_len(frm_len),
        .prmbl_len(prmbl_len), .dst_addr(dst_addr), .src_addr(src_addr),
        .len_type(len_type), .crc_ok(crc_ok), .phy_err(phy_err),
        .prmbl_err(prmbl_err), .dribble(dribble), .short_frm(short_frm),
        .frm_cnt(frm_cnt), .crc_err_cnt(crc_err_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct {
        int          cyc;
        logic [15:0] len;
        logic [4:0]  pl;
        logic [47:0] dst, src;
        logic [15:0] lt;
        logic        ok, phy, perr, drib, shrt;
        logic [15:0] fc, ec;
    } snap_t;

    snap_t       q[$];
    int          cyc = 0;
    int          last_beat = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [7:0]  fr [64];
    logic [47:0] e_dst, e_src;
    logic [15:0] e_lt;

    always @(posedge rx_clk) cyc <= cyc + 1;

    // Capture every summary pulse.
    always @(negedge rx_clk)
        if (frm_done === 1'b1)
            q.push_back('{cyc, frm_len, prmbl_len, dst_addr, src_addr, len_type,
                          crc_ok, phy_err, prmbl_err, dribble, short_frm, frm_cnt, crc_err_cnt});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic dv, input logic [7:0] d, input logic er, input logic rst);
        @(negedge rx_clk);
        rx_dv = dv; rxd = d; rx_er = er; reset = rst;
        if (dv) last_beat = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send(input bit mii, input int n, input int er_at, input bit xnib, input int rst_at);
        if (!mii) begin
            repeat (7) beat(1'b1, 8'h55, 1'b0, 1'b0);
            beat(1'b1, 8'hD5, 1'b0, 1'b0);
        end else begin
            repeat (15) beat(1'b1, 8'h05, 1'b0, 1'b0);
            beat(1'b1, 8'h0D, 1'b0, 1'b0);
        end
        for (int i = 0; i < n; i++) begin
            if (mii) begin
                beat(1'b1, {4'h0, fr[i][3:0]}, 1'b0, 1'b0);
                beat(1'b1, {4'h0, fr[i][7:4]}, 1'b0, 1'b0);
            end else begin
                beat(1'b1, fr[i], i == er_at, i == rst_at);
            end
        end
        if (xnib) beat(1'b1, 8'h0A, 1'b0, 1'b0);
        idle(6);
    endtask

    task automatic expect_frame(input string tag, input bit chk_lat, input int len, input int pl,
                                input bit ok, input bit phy, input bit perr, input bit drib,
                                input bit shrt, input bit chk_hdr, input int fc, input int ec);
        snap_t s;
        chk({tag, ".done"}, q.size() > 0, 1'b1);
        if (q.size() == 0) return;
        s = q.pop_front();
        if (chk_lat) chk({tag, ".lat"}, s.cyc - last_beat, 2);
        chk({tag, ".len"},   s.len,  len);
        chk({tag, ".prmbl"}, s.pl,   pl);
        chk({tag, ".crc_ok"}, s.ok,  ok);
        chk({tag, ".phy"},   s.phy,  phy);
        chk({tag, ".perr"},  s.perr, perr);
        chk({tag, ".drib"},  s.drib, drib);
        if (shrt || len > 0) chk({tag, ".short"}, s.shrt, shrt);
        if (chk_hdr) begin
            chk({tag, ".dst"}, s.dst, e_dst);
            chk({tag, ".src"}, s.src, e_src);
            chk({tag, ".lt"},  s.lt,  e_lt);
        end
        chk({tag, ".fcnt"}, s.fc, fc);
        chk({tag, ".ecnt"}, s.ec, ec);
    endtask

    initial begin
        logic [31:0] c, fcs;
        reset = 1'b1; mii_mode = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;

        // Reference frame: header, counting payload, FCS.
        fr[0] = 8'h00; fr[1] = 8'h11; fr[2]  = 8'h22; fr[3]  = 8'h33; fr[4]  = 8'h44; fr[5]  = 8'h55;
        fr[6] = 8'h66; fr[7] = 8'h77; fr[8]  = 8'h88; fr[9]  = 8'h99; fr[10] = 8'hAA; fr[11] = 8'hBB;
        fr[12] = 8'h08; fr[13] = 8'h00;
        for (int i = 14; i < 60; i++) fr[i] = 8'(i);
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            c = c ^ {24'h0, fr[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        fcs = ~c;
        fr[60] = fcs[7:0]; fr[61] = fcs[15:8]; fr[62] = fcs[23:16]; fr[63] = fcs[31:24];
        e_dst = 48'h0011_2233_4455; e_src = 48'h6677_8899_AABB; e_lt = 16'h0800;

        // Reset state
        repeat (3) @(negedge rx_clk);
        chk("rst.done", frm_done, 1'b0);
        chk("rst.len", frm_len, 16'h0);
        chk("rst.dst", dst_addr, 48'h0);
        chk("rst.fcnt", frm_cnt, 16'h0);
        chk("rst.ecnt", crc_err_cnt, 16'h0);
        idle(2);

        // GMII good frame
        send(1'b0, 64, -1, 1'b0, -1);
        expect_frame("gmii", 1'b1, 64, 7, 1, 0, 0, 0, 0, 1'b1, 1, 0);

        // MII good frame
        mii_mode = 1'b1; idle(2);
        send(1'b1, 64, -1, 1'b0, -1);
        expect_frame("mii", 1'b1, 64, 15, 1, 0, 0, 0, 0, 1'b1, 2, 0);
        mii_mode = 1'b0; idle(2);

        // Bad FCS
        fr[63] = ~fr[63];
        send(1'b0, 64, -1, 1'b0, -1);
        fr[63] = ~fr[63];
        expect_frame("badfcs", 1'b0, 64, 7, 0, 0, 0, 0, 0, 1'b1, 2, 1);

        // PHY error at byte 20
        send(1'b0, 64, 20, 1'b0, -1);
        expect_frame("phyerr", 1'b0, 64, 7, 1, 1, 0, 0, 0, 1'b1, 2, 1);

        // Bad preamble, one idle cycle, then good frame
        beat(1'b1, 8'h55, 1'b0, 1'b0);
        beat(1'b1, 8'h55, 1'b0, 1'b0);
        beat(1'b1, 8'h54, 1'b0, 1'b0);
        idle(1);
        send(1'b0, 64, -1, 1'b0, -1);
        expect_frame("badpre", 1'b0, 0, 2, 0, 0, 1, 0, 1, 1'b0, 2, 1);
        expect_frame("b2b", 1'b0, 64, 7, 1, 0, 0, 0, 0, 1'b1, 3, 1);

        // MII dribble nibble
        mii_mode = 1'b1; idle(2);
        send(1'b1, 64, -1, 1'b1, -1);
        expect_frame("drib", 1'b0, 64, 15, 1, 0, 0, 1, 0, 1'b1, 3, 1);
        mii_mode = 1'b0; idle(2);

        // Reset mid-frame at byte 30
        send(1'b0, 64, -1, 1'b0, 30);
        chk("midrst.nodone", q.size(), 0);
        chk("midrst.fcnt", frm_cnt, 16'h0);
        chk("midrst.ecnt", crc_err_cnt, 16'h0);
        chk("midrst.len", frm_len, 16'h0);
        chk("midrst.src", src_addr, 48'h0);
        q.delete();
        send(1'b0, 64, -1, 1'b0, -1);
        expect_frame("postrst", 1'b0, 64, 7, 1, 0, 0, 0, 0, 1'b1, 1, 0);

        // Short frame: 10 bytes, partial SRC, no length/type
        e_src = 48'h6677_8899_0000; e_lt = 16'h0000;
        send(1'b0, 10, -1, 1'b0, -1);
        expect_frame("short", 1'b0, 10, 7, 0, 0, 0, 0, 1, 1'b1, 1, 1);
        chk("final.extra", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
